// File: rtl/tlul_host_arb_n.sv
// rtl/tlul_host_arb_n.sv - N-host to 1-device TL-UL arbiter with in-order response tag FIFO
// TL-UL channels are flattened per host: host h occupies slice [h*W +: W] of each field bus.
module tlul_host_arb_n #(
    parameter int NumHosts       = 2,
    parameter int MaxOutstanding = 4,
    parameter bit FixedPrio      = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumHosts-1:0]                 tl_host_a_valid_i,
    input  logic [NumHosts*3-1:0]               tl_host_a_opcode_i,
    input  logic [NumHosts*32-1:0]              tl_host_a_address_i,
    input  logic [NumHosts*32-1:0]              tl_host_a_data_i,
    input  logic [NumHosts*4-1:0]               tl_host_a_mask_i,
    input  logic [NumHosts-1:0]                 tl_host_d_ready_i,
    output logic [NumHosts-1:0]                 tl_host_a_ready_o,
    output logic [NumHosts-1:0]                 tl_host_d_valid_o,
    output logic [NumHosts*3-1:0]               tl_host_d_opcode_o,
    output logic [NumHosts*32-1:0]              tl_host_d_data_o,
    output logic [NumHosts-1:0]                 tl_host_d_error_o,
    output logic                                tl_dev_a_valid_o,
    output logic [2:0]                          tl_dev_a_opcode_o,
    output logic [31:0]                         tl_dev_a_address_o,
    output logic [31:0]                         tl_dev_a_data_o,
    output logic [3:0]                          tl_dev_a_mask_o,
    output logic                                tl_dev_d_ready_o,
    input  logic                                tl_dev_a_ready_i,
    input  logic                                tl_dev_d_valid_i,
    input  logic [2:0]                          tl_dev_d_opcode_i,
    input  logic [31:0]                         tl_dev_d_data_i,
    input  logic                                tl_dev_d_error_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                err_unexp_rsp_o
);
    localparam int PW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int FW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] grant_q, grant_idx, arb_idx, ptr_q, head;
    logic          grant_valid, any_req, found;
    logic [PW-1:0] tag_mem [MaxOutstanding];
    logic [FW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, a_hs, d_hs;

    assign full          = (count_q == CW'(MaxOutstanding));
    assign empty         = (count_q == '0);
    assign head          = tag_mem[rd_ptr_q];
    assign a_hs          = grant_valid & tl_dev_a_ready_i & ~rst_i;
    assign d_hs          = ~empty & tl_dev_d_valid_i & tl_dev_d_ready_o;
    assign outstanding_o = count_q;

    always_comb begin : arbitrate
        arb_idx = '0;
        found   = 1'b0;
        any_req = |tl_host_a_valid_i;
        if (FixedPrio) begin
            for (int h = NumHosts - 1; h >= 0; h--) begin
                if (tl_host_a_valid_i[h]) arb_idx = PW'(h);
            end
        end else begin
            // Rotating search starting at ptr so the last winner goes to the back
            for (int off = 0; off < NumHosts; off++) begin
                if (!found && tl_host_a_valid_i[(int'(ptr_q) + off) % NumHosts]) begin
                    arb_idx = PW'((int'(ptr_q) + off) % NumHosts);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin : fsm
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_idx   = grant_q;
        case (state_q)
            IDLE: begin
                if (!full && any_req) begin
                    grant_valid = 1'b1;
                    grant_idx   = arb_idx;
                    if (!tl_dev_a_ready_i) state_d = HOLD;
                end
            end
            HOLD: begin
                grant_valid = 1'b1;
                if (tl_dev_a_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : route
        tl_host_a_ready_o  = '0;
        tl_host_d_valid_o  = '0;
        tl_host_d_opcode_o = '0;
        tl_host_d_data_o   = '0;
        tl_host_d_error_o  = '0;
        tl_dev_a_valid_o   = 1'b0;
        tl_dev_a_opcode_o  = '0;
        tl_dev_a_address_o = '0;
        tl_dev_a_data_o    = '0;
        tl_dev_a_mask_o    = '0;
        tl_dev_d_ready_o   = 1'b0;
        err_unexp_rsp_o    = 1'b0;
        // Outputs are forced low while reset is held, independent of the clock
        if (!rst_i) begin
            if (grant_valid) begin
                tl_dev_a_valid_o = 1'b1;
                for (int h = 0; h < NumHosts; h++) begin
                    if (grant_idx == PW'(h)) begin
                        tl_dev_a_opcode_o    = tl_host_a_opcode_i[h*3 +: 3];
                        tl_dev_a_address_o   = tl_host_a_address_i[h*32 +: 32];
                        tl_dev_a_data_o      = tl_host_a_data_i[h*32 +: 32];
                        tl_dev_a_mask_o      = tl_host_a_mask_i[h*4 +: 4];
                        tl_host_a_ready_o[h] = tl_dev_a_ready_i;
                    end
                end
            end
            if (empty) begin
                // Nobody owns this beat: swallow it and flag it
                tl_dev_d_ready_o = tl_dev_d_valid_i;
                err_unexp_rsp_o  = tl_dev_d_valid_i;
            end else begin
                for (int h = 0; h < NumHosts; h++) begin
                    if (head == PW'(h)) begin
                        tl_host_d_valid_o[h]         = tl_dev_d_valid_i;
                        tl_host_d_opcode_o[h*3 +: 3] = tl_dev_d_opcode_i;
                        tl_host_d_data_o[h*32 +: 32] = tl_dev_d_data_i;
                        tl_host_d_error_o[h]         = tl_dev_d_error_i;
                        tl_dev_d_ready_o             = tl_host_d_ready_i[h];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) grant_q <= grant_idx;
            if (a_hs) begin
                wr_ptr_q <= (wr_ptr_q == FW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
                if (!FixedPrio) ptr_q <= (grant_idx == PW'(NumHosts - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (d_hs) rd_ptr_q <= (rd_ptr_q == FW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (a_hs && !d_hs)      count_q <= count_q + 1'b1;
            else if (!a_hs && d_hs) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (a_hs) tag_mem[wr_ptr_q] <= grant_idx;
    end
endmodule

// File: tb/tb_tlul_host_arb_n.sv
// tb/tb_tlul_host_arb_n.sv - directed bench for tlul_host_arb_n (round-robin and fixed-priority)
module tb_tlul_host_arb_n;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  a_valid, d_ready;
    logic [8:0]  a_opcode;
    logic [95:0] a_address, a_data;
    logic [11:0] a_mask;
    logic        dev_a_ready, dev_d_valid, dev_d_error;
    logic [2:0]  dev_d_opcode;
    logic [31:0] dev_d_data;

    logic [2:0]  rr_a_ready, rr_d_valid, rr_d_error, rr_out, fp_a_ready, fp_d_valid, fp_d_error, fp_out;
    logic [8:0]  rr_d_opcode, fp_d_opcode;
    logic [95:0] rr_d_data, fp_d_data;
    logic        rr_dev_a_valid, rr_dev_d_ready, rr_err, fp_dev_a_valid, fp_dev_d_ready, fp_err;
    logic [2:0]  rr_dev_a_opcode, fp_dev_a_opcode;
    logic [31:0] rr_dev_a_address, rr_dev_a_data, fp_dev_a_address, fp_dev_a_data;
    logic [3:0]  rr_dev_a_mask, fp_dev_a_mask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlul_host_arb_n #(.NumHosts(3), .MaxOutstanding(4), .FixedPrio(1'b0)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .tl_host_a_valid_i(a_valid), .tl_host_a_opcode_i(a_opcode), .tl_host_a_address_i(a_address),
        .tl_host_a_data_i(a_data), .tl_host_a_mask_i(a_mask), .tl_host_d_ready_i(d_ready),
        .tl_host_a_ready_o(rr_a_ready), .tl_host_d_valid_o(rr_d_valid), .tl_host_d_opcode_o(rr_d_opcode),
        .tl_host_d_data_o(rr_d_data), .tl_host_d_error_o(rr_d_error),
        .tl_dev_a_valid_o(rr_dev_a_valid), .tl_dev_a_opcode_o(rr_dev_a_opcode),
        .tl_dev_a_address_o(rr_dev_a_address), .tl_dev_a_data_o(rr_dev_a_data),
        .tl_dev_a_mask_o(rr_dev_a_mask), .tl_dev_d_ready_o(rr_dev_d_ready),
        .tl_dev_a_ready_i(dev_a_ready), .tl_dev_d_valid_i(dev_d_valid), .tl_dev_d_opcode_i(dev_d_opcode),
        .tl_dev_d_data_i(dev_d_data), .tl_dev_d_error_i(dev_d_error),
        .outstanding_o(rr_out), .err_unexp_rsp_o(rr_err)
    );

    tlul_host_arb_n #(.NumHosts(3), .MaxOutstanding(4), .FixedPrio(1'b1)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .tl_host_a_valid_i(a_valid), .tl_host_a_opcode_i(a_opcode), .tl_host_a_address_i(a_address),
        .tl_host_a_data_i(a_data), .tl_host_a_mask_i(a_mask), .tl_host_d_ready_i(d_ready),
        .tl_host_a_ready_o(fp_a_ready), .tl_host_d_valid_o(fp_d_valid), .tl_host_d_opcode_o(fp_d_opcode),
        .tl_host_d_data_o(fp_d_data), .tl_host_d_error_o(fp_d_error),
        .tl_dev_a_valid_o(fp_dev_a_valid), .tl_dev_a_opcode_o(fp_dev_a_opcode),
        .tl_dev_a_address_o(fp_dev_a_address), .tl_dev_a_data_o(fp_dev_a_data),
        .tl_dev_a_mask_o(fp_dev_a_mask), .tl_dev_d_ready_o(fp_dev_d_ready),
        .tl_dev_a_ready_i(dev_a_ready), .tl_dev_d_valid_i(dev_d_valid), .tl_dev_d_opcode_i(dev_d_opcode),
        .tl_dev_d_data_i(dev_d_data), .tl_dev_d_error_i(dev_d_error),
        .outstanding_o(fp_out), .err_unexp_rsp_o(fp_err)
    );

    typedef struct {
        logic [2:0]  a_valid;
        logic        dev_a_ready;
        logic        d_valid;
        logic [31:0] d_data;
        logic [2:0]  d_ready;
        logic        e_a_valid;
        logic [1:0]  e_grant;
        logic [2:0]  e_a_ready;
        logic [2:0]  e_d_valid;
        logic        e_d_ready;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] host_addr(input int h);
        return 32'h1000_0000 + 32'(h * 16);
    endfunction

    task automatic cyc(input logic [2:0] av, input logic ar, input logic dv, input logic [31:0] dd);
        @(negedge clk);
        a_valid     = av;
        dev_a_ready = ar;
        dev_d_valid = dv;
        dev_d_data  = dd;
        #2;
    endtask

    initial begin
        // Stream: all hosts request, every beat accepted, each response one cycle behind its request
        tbl[0] = '{3'b111, 1'b1, 1'b0, 32'h0,         3'b111, 1'b1, 2'd0, 3'b001, 3'b000, 1'b0, 3'd0, 1'b0};
        tbl[1] = '{3'b111, 1'b1, 1'b1, 32'hD000_0000, 3'b111, 1'b1, 2'd1, 3'b010, 3'b001, 1'b1, 3'd1, 1'b0};
        tbl[2] = '{3'b111, 1'b1, 1'b1, 32'hD000_0001, 3'b111, 1'b1, 2'd2, 3'b100, 3'b010, 1'b1, 3'd1, 1'b0};
        tbl[3] = '{3'b111, 1'b1, 1'b1, 32'hD000_0002, 3'b111, 1'b1, 2'd0, 3'b001, 3'b100, 1'b1, 3'd1, 1'b0};
        tbl[4] = '{3'b111, 1'b1, 1'b1, 32'hD000_0003, 3'b111, 1'b1, 2'd1, 3'b010, 3'b001, 1'b1, 3'd1, 1'b0};
        tbl[5] = '{3'b111, 1'b1, 1'b1, 32'hD000_0004, 3'b111, 1'b1, 2'd2, 3'b100, 3'b010, 1'b1, 3'd1, 1'b0};
        tbl[6] = '{3'b000, 1'b1, 1'b1, 32'hD000_0005, 3'b111, 1'b0, 2'd0, 3'b000, 3'b100, 1'b1, 3'd1, 1'b0};
        tbl[7] = '{3'b000, 1'b1, 1'b0, 32'h0,         3'b111, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0};
        tbl[8] = '{3'b000, 1'b1, 1'b1, 32'hEEEE_EEEE, 3'b111, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1, 3'd0, 1'b1};
        tbl[9] = '{3'b000, 1'b1, 1'b0, 32'h0,         3'b111, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0, 3'd0, 1'b0};

        for (int h = 0; h < 3; h++) begin
            a_opcode[h*3 +: 3]   = 3'(h + 1);
            a_address[h*32 +: 32] = host_addr(h);
            a_data[h*32 +: 32]    = 32'hA0 + 32'(h);
            a_mask[h*4 +: 4]      = 4'hF;
        end
        d_ready      = 3'b111;
        dev_d_opcode = 3'd1;
        dev_d_error  = 1'b0;
        dev_d_data   = 32'h0;
        a_valid      = 3'b111;
        dev_a_ready  = 1'b1;
        dev_d_valid  = 1'b1;

        #7;
        chk("rst dev_a_valid", 32'(rr_dev_a_valid), 32'd0);
        chk("rst a_ready", 32'(rr_a_ready), 32'd0);
        chk("rst d_valid", 32'(rr_d_valid), 32'd0);
        chk("rst dev_d_ready", 32'(rr_dev_d_ready), 32'd0);
        chk("rst outstanding", 32'(rr_out), 32'd0);
        chk("rst err", 32'(rr_err), 32'd0);
        chk("rst fp dev_a_valid", 32'(fp_dev_a_valid), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        a_valid     = 3'b000;
        dev_d_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].a_valid, tbl[i].dev_a_ready, tbl[i].d_valid, tbl[i].d_data);
            d_ready = tbl[i].d_ready;
            #1;
            chk($sformatf("row%0d dev_a_valid", i), 32'(rr_dev_a_valid), 32'(tbl[i].e_a_valid));
            if (tbl[i].e_a_valid) begin
                chk($sformatf("row%0d grant addr", i), rr_dev_a_address, host_addr(int'(tbl[i].e_grant)));
                chk($sformatf("row%0d grant data", i), rr_dev_a_data, 32'hA0 + 32'(tbl[i].e_grant));
            end
            chk($sformatf("row%0d a_ready", i), 32'(rr_a_ready), 32'(tbl[i].e_a_ready));
            chk($sformatf("row%0d d_valid", i), 32'(rr_d_valid), 32'(tbl[i].e_d_valid));
            chk($sformatf("row%0d dev_d_ready", i), 32'(rr_dev_d_ready), 32'(tbl[i].e_d_ready));
            chk($sformatf("row%0d outstanding", i), 32'(rr_out), 32'(tbl[i].e_out));
            chk($sformatf("row%0d err", i), 32'(rr_err), 32'(tbl[i].e_err));
            for (int h = 0; h < 3; h++) begin
                if (tbl[i].e_d_valid[h]) chk($sformatf("row%0d d_data h%0d", i, h), rr_d_data[h*32 +: 32], tbl[i].d_data);
            end
        end

        // Grant held on host1 through device back-pressure, host0 served next
        for (int k = 0; k < 3; k++) begin
            cyc((k == 0) ? 3'b010 : 3'b011, 1'b0, 1'b0, 32'h0);
            chk($sformatf("hold%0d dev_a_valid", k), 32'(rr_dev_a_valid), 32'd1);
            chk($sformatf("hold%0d grant", k), rr_dev_a_address, host_addr(1));
            chk($sformatf("hold%0d a_ready", k), 32'(rr_a_ready), 32'd0);
        end
        cyc(3'b011, 1'b1, 1'b0, 32'h0);
        chk("hold accept grant", rr_dev_a_address, host_addr(1));
        chk("hold accept a_ready", 32'(rr_a_ready), 32'b010);
        cyc(3'b001, 1'b1, 1'b0, 32'h0);
        chk("after hold grant", rr_dev_a_address, host_addr(0));
        chk("after hold a_ready", 32'(rr_a_ready), 32'b001);
        chk("after hold outstanding", 32'(rr_out), 32'd1);
        cyc(3'b000, 1'b1, 1'b1, 32'hD000_0100);
        chk("drain1 d_valid", 32'(rr_d_valid), 32'b010);
        chk("drain1 d_data", rr_d_data[32 +: 32], 32'hD000_0100);
        chk("drain1 outstanding", 32'(rr_out), 32'd2);
        cyc(3'b000, 1'b1, 1'b1, 32'hD000_0101);
        chk("drain2 d_valid", 32'(rr_d_valid), 32'b001);
        chk("drain2 d_data", rr_d_data[31:0], 32'hD000_0101);
        cyc(3'b000, 1'b1, 1'b0, 32'h0);
        chk("drained outstanding", 32'(rr_out), 32'd0);

        // Fill the tag FIFO with no responses, then free one slot
        for (int k = 0; k < 4; k++) begin
            cyc(3'b001, 1'b1, 1'b0, 32'h0);
            chk($sformatf("fill%0d a_ready", k), 32'(rr_a_ready), 32'b001);
            chk($sformatf("fill%0d outstanding", k), 32'(rr_out), 32'(k));
        end
        for (int k = 0; k < 2; k++) begin
            cyc(3'b001, 1'b1, 1'b0, 32'h0);
            chk($sformatf("full%0d dev_a_valid", k), 32'(rr_dev_a_valid), 32'd0);
            chk($sformatf("full%0d a_ready", k), 32'(rr_a_ready), 32'd0);
            chk($sformatf("full%0d outstanding", k), 32'(rr_out), 32'd4);
        end
        cyc(3'b001, 1'b1, 1'b1, 32'hD000_0200);
        chk("full pop dev_a_valid", 32'(rr_dev_a_valid), 32'd0);
        chk("full pop a_ready", 32'(rr_a_ready), 32'd0);
        chk("full pop d_valid", 32'(rr_d_valid), 32'b001);
        chk("full pop dev_d_ready", 32'(rr_dev_d_ready), 32'd1);
        cyc(3'b001, 1'b1, 1'b0, 32'h0);
        chk("fifth dev_a_valid", 32'(rr_dev_a_valid), 32'd1);
        chk("fifth a_ready", 32'(rr_a_ready), 32'b001);
        chk("fifth outstanding", 32'(rr_out), 32'd3);
        cyc(3'b000, 1'b1, 1'b1, 32'hD000_0201);
        chk("pop outstanding", 32'(rr_out), 32'd4);

        // Asynchronous reset with three tags in flight
        cyc(3'b111, 1'b1, 1'b1, 32'hD000_0202);
        chk("pre-rst outstanding", 32'(rr_out), 32'd3);
        chk("pre-rst d_valid", 32'(rr_d_valid), 32'b001);
        rst = 1'b1;
        #1;
        chk("async rst dev_a_valid", 32'(rr_dev_a_valid), 32'd0);
        chk("async rst a_ready", 32'(rr_a_ready), 32'd0);
        chk("async rst d_valid", 32'(rr_d_valid), 32'd0);
        chk("async rst dev_d_ready", 32'(rr_dev_d_ready), 32'd0);
        chk("async rst outstanding", 32'(rr_out), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        a_valid     = 3'b000;
        dev_d_valid = 1'b1;
        dev_d_data  = 32'hD000_0203;
        #2;
        chk("post-rst d_valid", 32'(rr_d_valid), 32'd0);
        chk("post-rst err", 32'(rr_err), 32'd1);
        chk("post-rst outstanding", 32'(rr_out), 32'd0);

        // Hosts 0 and 2 streaming: fixed priority starves host2, round-robin alternates
        for (int k = 0; k < 6; k++) begin
            cyc(3'b101, 1'b1, (k > 0), 32'hD000_0300 + 32'(k));
            chk($sformatf("fp%0d grant", k), fp_dev_a_address, host_addr(0));
            chk($sformatf("fp%0d a_ready", k), 32'(fp_a_ready), 32'b001);
            chk($sformatf("rr%0d grant", k), rr_dev_a_address, host_addr((k % 2 == 0) ? 0 : 2));
        end
        cyc(3'b100, 1'b1, 1'b1, 32'hD000_0306);
        chk("fp host2 grant", fp_dev_a_address, host_addr(2));
        chk("fp host2 a_ready", 32'(fp_a_ready), 32'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
